approx_recovery_accum: RTL and testbench

- Sequential final stage of the approximate 16x16 multiplier with error recovery. Sits directly downstream of the Layer-2 reduction stage.
- Consumes the four Layer-2 sum rows (c1..c4) and the four error vectors (ei..el). Accumulates them into a product over several cycles using one shared 33-bit adder.
- Supports a configurable number of error-recovery passes. Reports both the uncorrected approximate sum and the recovered sum.

---
 rtl/approx_recovery_accum.sv | 165 ++++++++++++++++
 tb/tb_approx_recovery_accum.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/approx_recovery_accum.sv
// rtl/approx_recovery_accum.sv - multi-cycle row/error accumulator for the approximate 16x16 multiplier
module approx_recovery_accum #(
  parameter int NUM_REC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [19:1]  c1,
  input  logic [23:5]  c2,
  input  logic [27:9]  c3,
  input  logic [31:13] c4,
  input  logic [18:3]  ei,
  input  logic [22:7]  ej,
  input  logic [26:11] ek,
  input  logic [30:15] el,
  output logic [32:0]  approx_sum,
  output logic [32:0]  result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    REC  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Index of the last error pass; only meaningful when NUM_REC > 0.
  localparam int          LAST_REC_INT = (NUM_REC > 4) ? 3 : ((NUM_REC > 0) ? NUM_REC - 1 : 0);
  localparam logic [1:0]  LAST_REC     = 2'(LAST_REC_INT);

  state_t        state_q, state_d;
  logic [32:0]   acc_q, acc_d;
  logic [1:0]    idx_q, idx_d;
  logic [32:0]   approx_q, approx_d;
  logic [32:0]   result_q, result_d;
  logic          cap_en;

  logic [19:1]   c1_q;
  logic [23:5]   c2_q;
  logic [27:9]   c3_q;
  logic [31:13]  c4_q;
  logic [18:3]   ei_q;
  logic [22:7]   ej_q;
  logic [26:11]  ek_q;
  logic [30:15]  el_q;

  logic [32:0]   row_op;
  logic [32:0]   err_op;
  logic [32:0]   add_op;
  logic [32:0]   sum;

  // Place the selected captured vector at its binary weight in the 33-bit frame.
  always_comb begin
    row_op = '0;
    err_op = '0;
    case (idx_q)
      2'd0: begin row_op = {13'd0, c1_q, 1'b0};  err_op = {14'd0, ei_q, 3'b0};  end
      2'd1: begin row_op = {9'd0,  c2_q, 5'b0};  err_op = {10'd0, ej_q, 7'b0};  end
      2'd2: begin row_op = {5'd0,  c3_q, 9'b0};  err_op = {6'd0,  ek_q, 11'b0}; end
      default: begin row_op = {1'b0, c4_q, 13'b0}; err_op = {2'd0, el_q, 15'b0}; end
    endcase
    add_op = (state_q == REC) ? err_op : row_op;
    sum    = acc_q + add_op;
  end

  // Next-state and datapath control for the IDLE/ACC/REC/DONE sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    approx_d = approx_q;
    result_d = result_q;
    cap_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cap_en  = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = sum;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          approx_d = sum;
          idx_d    = '0;
          if (NUM_REC == 0) begin
            result_d = sum;
            state_d  = DONE;
          end else begin
            state_d  = REC;
          end
        end
      end
      REC: begin
        acc_d = sum;
        idx_d = idx_q + 2'd1;
        if (idx_q == LAST_REC) begin
          result_d = sum;
          idx_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      approx_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      approx_q <= approx_d;
      result_q <= result_d;
    end
  end

  // Operand capture, only on the accept edge so busy-time input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_q <= '0;
      c2_q <= '0;
      c3_q <= '0;
      c4_q <= '0;
      ei_q <= '0;
      ej_q <= '0;
      ek_q <= '0;
      el_q <= '0;
    end else if (cap_en) begin
      c1_q <= c1;
      c2_q <= c2;
      c3_q <= c3;
      c4_q <= c4;
      ei_q <= ei;
      ej_q <= ej;
      ek_q <= ek;
      el_q <= el;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign approx_sum = approx_q;
  assign result     = result_q;

endmodule

// File: tb/tb_approx_recovery_accum.sv
// tb/tb_approx_recovery_accum.sv - directed table-driven bench for approx_recovery_accum
module tb_approx_recovery_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [18:0] c1_s, c2_s, c3_s, c4_s;
  logic [15:0] ei_s, ej_s, ek_s, el_s;

  logic        iv0, ir0, ov0, or0, bz0;
  logic [32:0] apx0, res0;
  logic        iv1, ir1, ov1, or1, bz1;
  logic [32:0] apx1, res1;

  approx_recovery_accum #(.NUM_REC(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .c1(c1_s), .c2(c2_s), .c3(c3_s), .c4(c4_s),
    .ei(ei_s), .ej(ej_s), .ek(ek_s), .el(el_s),
    .approx_sum(apx0), .result(res0), .out_valid(ov0), .out_ready(or0), .busy(bz0)
  );

  approx_recovery_accum #(.NUM_REC(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .c1(c1_s), .c2(c2_s), .c3(c3_s), .c4(c4_s),
    .ei(ei_s), .ej(ej_s), .ek(ek_s), .el(el_s),
    .approx_sum(apx1), .result(res1), .out_valid(ov1), .out_ready(or1), .busy(bz1)
  );

  typedef struct {
    logic [18:0] c1, c2, c3, c4;
    logic [15:0] ei, ej, ek, el;
    logic [32:0] exp_approx;
    logic [32:0] exp_res4;
  } vec_t;

  vec_t tbl [5];
  int tests  = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic ov_of(input int d);  return (d == 0) ? ov0 : ov1;   endfunction
  function automatic logic ir_of(input int d);  return (d == 0) ? ir0 : ir1;   endfunction
  function automatic logic bz_of(input int d);  return (d == 0) ? bz0 : bz1;   endfunction
  function automatic logic [32:0] res_of(input int d); return (d == 0) ? res0 : res1; endfunction
  function automatic logic [32:0] apx_of(input int d); return (d == 0) ? apx0 : apx1; endfunction

  task automatic set_iv(input int d, input logic v);
    if (d == 0) iv0 = v; else iv1 = v;
  endtask

  task automatic set_or(input int d, input logic v);
    if (d == 0) or0 = v; else or1 = v;
  endtask

  task automatic drive(input vec_t v);
    c1_s = v.c1; c2_s = v.c2; c3_s = v.c3; c4_s = v.c4;
    ei_s = v.ei; ej_s = v.ej; ek_s = v.ek; el_s = v.el;
  endtask

  task automatic drive_garbage();
    c1_s = 19'($urandom); c2_s = 19'($urandom); c3_s = 19'($urandom); c4_s = 19'($urandom);
    ei_s = 16'($urandom); ej_s = 16'($urandom); ek_s = 16'($urandom); el_s = 16'($urandom);
  endtask

  // Accept one operand set on DUT d, scramble inputs while busy, hold off
  // the consumer for 'hold' cycles, then complete the handshake.
  task automatic run_op(input int d, input vec_t v, input int hold, input string tag);
    int nrec;
    int cnt;
    logic [32:0] exp_res;
    logic [32:0] r_hold, a_hold;
    nrec    = (d == 0) ? 0 : 4;
    exp_res = (d == 0) ? v.exp_approx : v.exp_res4;
    set_or(d, (hold == 0));
    drive(v);
    check({tag, " in_ready_before"}, 33'(ir_of(d)), 33'd1);
    set_iv(d, 1'b1);
    @(posedge clk); #1;
    cnt = 0;
    while (ov_of(d) !== 1'b1 && cnt < 30) begin
      check({tag, " in_ready_busy"}, 33'(ir_of(d)), 33'd0);
      check({tag, " busy_busy"}, 33'(bz_of(d)), 33'd1);
      set_iv(d, 1'(cnt));
      drive_garbage();
      @(posedge clk); #1;
      cnt++;
    end
    set_iv(d, 1'b0);
    drive(v);
    if (ov_of(d) !== 1'b1) begin
      check({tag, " timeout_out_valid"}, 33'(ov_of(d)), 33'd1);
    end else begin
      check({tag, " latency"}, 33'(cnt), 33'(4 + nrec));
      check({tag, " approx_sum"}, apx_of(d), v.exp_approx);
      check({tag, " result"}, res_of(d), exp_res);
      r_hold = res_of(d);
      a_hold = apx_of(d);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, " hold_out_valid"}, 33'(ov_of(d)), 33'd1);
        check({tag, " hold_result"}, res_of(d), exp_res);
        check({tag, " hold_approx"}, apx_of(d), a_hold);
        check({tag, " hold_in_ready"}, 33'(ir_of(d)), 33'd0);
      end
      set_or(d, 1'b1);
      @(posedge clk); #1;
      check({tag, " post_out_valid"}, 33'(ov_of(d)), 33'd0);
      check({tag, " post_in_ready"}, 33'(ir_of(d)), 33'd1);
      check({tag, " post_busy"}, 33'(bz_of(d)), 33'd0);
      check({tag, " idle_keeps_result"}, res_of(d), r_hold);
    end
  endtask

  initial begin
    tbl[0] = '{c1: 19'd1, c2: 19'd1, c3: 19'd1, c4: 19'd1,
               ei: 16'd1, ej: 16'd1, ek: 16'd1, el: 16'd1,
               exp_approx: 33'd8738, exp_res4: 33'd43690};
    tbl[1] = '{c1: 19'h0F0F0, c2: 19'h0F0F0, c3: 19'h0F0F0, c4: 19'h0F0F0,
               ei: 16'd0, ej: 16'd0, ek: 16'd0, el: 16'd0,
               exp_approx: 33'd538959840, exp_res4: 33'd538959840};
    tbl[2] = '{c1: 19'h7FFFF, c2: 19'd0, c3: 19'd0, c4: 19'd0,
               ei: 16'd0, ej: 16'd0, ek: 16'd0, el: 16'hFFFF,
               exp_approx: 33'd1048574, exp_res4: 33'd2148499454};
    tbl[3] = '{c1: 19'd0, c2: 19'd0, c3: 19'd0, c4: 19'd0,
               ei: 16'd0, ej: 16'd0, ek: 16'd1, el: 16'd0,
               exp_approx: 33'd0, exp_res4: 33'd2048};
    tbl[4] = '{c1: 19'd3, c2: 19'd0, c3: 19'd0, c4: 19'd0,
               ei: 16'd5, ej: 16'd0, ek: 16'd0, el: 16'd0,
               exp_approx: 33'd6, exp_res4: 33'd46};

    rst = 1'b1;
    iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
    drive(tbl[3]);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      check("reset in_ready", 33'(ir_of(d)), 33'd1);
      check("reset out_valid", 33'(ov_of(d)), 33'd0);
      check("reset busy", 33'(bz_of(d)), 33'd0);
      check("reset result", res_of(d), 33'd0);
      check("reset approx_sum", apx_of(d), 33'd0);
    end

    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < 2; d++) begin
        run_op(d, tbl[i], 0, $sformatf("vec%0d dut%0d", i, d));
      end
    end

    run_op(1, tbl[1], 10, "backpressure dut1");
    run_op(0, tbl[0], 10, "backpressure dut0");

    // Reset midway through the error-recovery passes.
    or1 = 1'b1;
    drive(tbl[0]);
    iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrec busy_before_reset", 33'(bz1), 33'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrec in_ready", 33'(ir1), 33'd1);
    check("midrec busy", 33'(bz1), 33'd0);
    check("midrec out_valid", 33'(ov1), 33'd0);
    check("midrec result", res1, 33'd0);
    check("midrec approx_sum", apx1, 33'd0);
    repeat (6) @(posedge clk);
    #1;
    check("midrec no_late_valid", 33'(ov1), 33'd0);
    run_op(1, tbl[0], 0, "after_reset dut1");

    // Reset and in_valid together: reset wins, nothing captured.
    drive(tbl[2]);
    rst = 1'b1;
    iv1 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    iv1 = 1'b0;
    check("rst_and_valid in_ready", 33'(ir1), 33'd1);
    check("rst_and_valid busy", 33'(bz1), 33'd0);
    repeat (8) @(posedge clk);
    #1;
    check("rst_and_valid no_output", 33'(ov1), 33'd0);
    check("rst_and_valid result", res1, 33'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
